// File: rtl/branch_jump_unit_pkg.sv
// rtl/branch_jump_unit_pkg.sv - shared encodings for the branch/jump unit
package branch_jump_unit_pkg;

    localparam logic [1:0] JMP_NOP = 2'd0;
    localparam logic [1:0] JAL     = 2'd1;
    localparam logic [1:0] JALR    = 2'd2;
    localparam logic [1:0] BRANCH  = 2'd3;

    localparam logic [2:0] BEQ  = 3'd0;
    localparam logic [2:0] BNE  = 3'd1;
    localparam logic [2:0] BLT  = 3'd4;
    localparam logic [2:0] BGE  = 3'd5;
    localparam logic [2:0] BLTU = 3'd6;
    localparam logic [2:0] BGEU = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

endpackage

// File: rtl/branch_jump_unit_branch_cmp.sv
// rtl/branch_jump_unit_branch_cmp.sv - conditional branch comparator
module branch_cmp
    import branch_jump_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      branch_op,
    output logic            taken,
    output logic            illegal
);

    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;

    assign w_eq   = (rs1 == rs2);
    assign w_lt_s = ($signed(rs1) < $signed(rs2));
    assign w_lt_u = (rs1 < rs2);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (branch_op)
            BEQ:     taken = w_eq;
            BNE:     taken = ~w_eq;
            BLT:     taken = w_lt_s;
            BGE:     taken = ~w_lt_s;
            BLTU:    taken = w_lt_u;
            BGEU:    taken = ~w_lt_u;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_jump_unit.sv
// rtl/branch_jump_unit.sv - JAL/JALR/branch resolution with wrong-path flush sequencer
// Optional taken/not-taken statistics counters under JUMP_STATS_EN.
module branch_jump_unit
    import branch_jump_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int ALIGN_BITS   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            ctrl_valid,
    input  logic [1:0]      jump_control,
    input  logic [2:0]      branch_op,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            rd_write_control,
    output logic [XLEN-1:0] rd_write_val,
    output logic            pc_update_control,
    output logic [XLEN-1:0] pc_update_val,
    output logic            ignore_curr_inst,
`ifdef JUMP_STATS_EN
    output logic [31:0]     taken_cnt,
    output logic [31:0]     not_taken_cnt,
`endif
    output logic            misaligned_exc
);

    flush_state_t r_state, w_state_nxt;
    logic [3:0]   r_cnt, w_cnt_nxt;

    logic            w_accept;
    logic            w_cmp_taken;
    logic            w_cmp_illegal;
    logic            w_taken;
    logic            w_is_link;
    logic            w_is_branch;
    logic            w_misaligned;
    logic [XLEN-1:0] w_target;

    branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
        .rs1       (rs1_val),
        .rs2       (rs2_val),
        .branch_op (branch_op),
        .taken     (w_cmp_taken),
        .illegal   (w_cmp_illegal)
    );

    assign ignore_curr_inst = (r_state == FLUSH);
    // i_rst gates acceptance so every combinational output is 0 while in reset.
    assign w_accept = i_rst & ctrl_valid & ~ignore_curr_inst;

    always_comb begin
        w_target    = pc + imm;
        w_taken     = 1'b0;
        w_is_link   = 1'b0;
        w_is_branch = 1'b0;
        case (jump_control)
            JAL: begin
                w_taken   = 1'b1;
                w_is_link = 1'b1;
            end
            JALR: begin
                w_target  = (rs1_val + imm) & ~XLEN'(1);
                w_taken   = 1'b1;
                w_is_link = 1'b1;
            end
            BRANCH: begin
                w_is_branch = ~w_cmp_illegal;
                w_taken     = w_cmp_taken & ~w_cmp_illegal;
            end
            default: ;
        endcase
    end

    assign w_misaligned      = w_accept & w_taken & (w_target[ALIGN_BITS-1:0] != '0);
    assign misaligned_exc    = w_misaligned;
    assign pc_update_control = w_accept & w_taken & ~w_misaligned;
    assign pc_update_val     = pc_update_control ? w_target : '0;
    assign rd_write_control  = w_accept & w_is_link & ~w_misaligned;
    assign rd_write_val      = rd_write_control ? (pc + XLEN'(4)) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (pc_update_control) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = 4'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef JUMP_STATS_EN
    logic [31:0] r_taken_cnt;
    logic [31:0] r_not_taken_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_taken_cnt     <= 32'd0;
            r_not_taken_cnt <= 32'd0;
        end else begin
            if (pc_update_control && r_taken_cnt != 32'hFFFF_FFFF)
                r_taken_cnt <= r_taken_cnt + 32'd1;
            if (w_accept && w_is_branch && !w_taken && r_not_taken_cnt != 32'hFFFF_FFFF)
                r_not_taken_cnt <= r_not_taken_cnt + 32'd1;
        end
    end

    assign taken_cnt     = r_taken_cnt;
    assign not_taken_cnt = r_not_taken_cnt;
`endif

endmodule

// File: tb/tb_branch_jump_unit.sv
// tb/tb_branch_jump_unit.sv - directed self-checking bench for branch_jump_unit
module tb_branch_jump_unit;

    localparam int FC = 3;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        ctrl_valid = 1'b0;
    logic [1:0]  jump_control = 2'd0;
    logic [2:0]  branch_op = 3'd0;
    logic [31:0] pc = '0, imm = '0, rs1_val = '0, rs2_val = '0;

    logic        rd_wc, pc_uc, ign, mis;
    logic [31:0] rd_wv, pc_uv;
    logic        rd_wc1, pc_uc1, ign1, mis1;
    logic [31:0] rd_wv1, pc_uv1;
`ifdef JUMP_STATS_EN
    logic [31:0] tk_cnt, ntk_cnt, tk_cnt1, ntk_cnt1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    branch_jump_unit #(.XLEN(32), .FLUSH_CYCLES(FC), .ALIGN_BITS(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .ctrl_valid(ctrl_valid),
        .jump_control(jump_control), .branch_op(branch_op), .pc(pc), .imm(imm),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rd_write_control(rd_wc), .rd_write_val(rd_wv),
        .pc_update_control(pc_uc), .pc_update_val(pc_uv),
        .ignore_curr_inst(ign),
`ifdef JUMP_STATS_EN
        .taken_cnt(tk_cnt), .not_taken_cnt(ntk_cnt),
`endif
        .misaligned_exc(mis)
    );

    branch_jump_unit #(.XLEN(32), .FLUSH_CYCLES(1), .ALIGN_BITS(2)) dut1 (
        .i_clk(i_clk), .i_rst(i_rst), .ctrl_valid(ctrl_valid),
        .jump_control(jump_control), .branch_op(branch_op), .pc(pc), .imm(imm),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rd_write_control(rd_wc1), .rd_write_val(rd_wv1),
        .pc_update_control(pc_uc1), .pc_update_val(pc_uv1),
        .ignore_curr_inst(ign1),
`ifdef JUMP_STATS_EN
        .taken_cnt(tk_cnt1), .not_taken_cnt(ntk_cnt1),
`endif
        .misaligned_exc(mis1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] jc, input logic [2:0] op, input logic [31:0] p,
                         input logic [31:0] im, input logic [31:0] a, input logic [31:0] b);
        ctrl_valid   = 1'b1;
        jump_control = jc;
        branch_op    = op;
        pc           = p;
        imm          = im;
        rs1_val      = a;
        rs2_val      = b;
        #1;
    endtask

    // Let the redirect be sampled, then idle until the main DUT is out of FLUSH.
    task automatic ride_flush();
        cyc();
        ctrl_valid = 1'b0;
        repeat (FC) cyc();
    endtask

    initial begin
        drive(2'd1, 3'd0, 32'h100, 32'h20, 32'h0, 32'h0);
        chk("rst_pc_uc", {31'b0, pc_uc}, 32'd0);
        chk("rst_rd_wc", {31'b0, rd_wc}, 32'd0);
        chk("rst_pc_uv", pc_uv, 32'h0);
        chk("rst_ign", {31'b0, ign}, 32'd0);

        @(posedge i_clk);
        #1 i_rst = 1'b1;
        #1;
        chk("jal_pc_uc", {31'b0, pc_uc}, 32'd1);
        chk("jal_pc_uv", pc_uv, 32'h120);
        chk("jal_rd_wc", {31'b0, rd_wc}, 32'd1);
        chk("jal_rd_wv", rd_wv, 32'h104);
        chk("jal1_pc_uv", pc_uv1, 32'h120);

        // JAL kept valid: squashed during FLUSH, accepted in first cycle after.
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("ign_fc3_c%0d", k), {31'b0, ign}, (k <= FC) ? 32'd1 : 32'd0);
            chk($sformatf("pcuc_fc3_c%0d", k), {31'b0, pc_uc}, (k <= FC) ? 32'd0 : 32'd1);
            if (k <= 2)
                chk($sformatf("ign_fc1_c%0d", k), {31'b0, ign1}, (k == 1) ? 32'd1 : 32'd0);
        end
        chk("b2b_pc_uv", pc_uv, 32'h120);
        ride_flush();
        chk("b2b_ign_done", {31'b0, ign}, 32'd0);

        drive(2'd2, 3'd0, 32'h300, 32'h4, 32'h2001, 32'h0);
        chk("jalr_pc_uv", pc_uv, 32'h2004);
        chk("jalr_rd_wv", rd_wv, 32'h304);
        chk("jalr_mis", {31'b0, mis}, 32'd0);
        ride_flush();

        drive(2'd2, 3'd0, 32'h300, 32'h0, 32'h2002, 32'h0);
        chk("jalr_mis_exc", {31'b0, mis}, 32'd1);
        chk("jalr_mis_pcuc", {31'b0, pc_uc}, 32'd0);
        chk("jalr_mis_rdwc", {31'b0, rd_wc}, 32'd0);
        cyc();
        chk("jalr_mis_noflush", {31'b0, ign}, 32'd0);

        drive(2'd3, 3'd4, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1);
        chk("blt_pc_uc", {31'b0, pc_uc}, 32'd1);
        chk("blt_pc_uv", pc_uv, 32'h210);
        chk("blt_rd_wc", {31'b0, rd_wc}, 32'd0);
        ride_flush();

        drive(2'd3, 3'd6, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1);
        chk("bltu_pc_uc", {31'b0, pc_uc}, 32'd0);
        chk("bltu_pc_uv", pc_uv, 32'h0);
        cyc();
        chk("bltu_noflush", {31'b0, ign}, 32'd0);

        drive(2'd3, 3'd0, 32'h400, 32'h8, 32'h5, 32'h5);
        chk("beq_pc_uv", pc_uv, 32'h408);
        ride_flush();

        drive(2'd3, 3'd1, 32'h400, 32'h8, 32'h5, 32'h5);
        chk("bne_pc_uc", {31'b0, pc_uc}, 32'd0);
        drive(2'd3, 3'd2, 32'h400, 32'h8, 32'h5, 32'h5);
        chk("illegal_pc_uc", {31'b0, pc_uc}, 32'd0);
        chk("illegal_mis", {31'b0, mis}, 32'd0);
        drive(2'd0, 3'd0, 32'h400, 32'h8, 32'h5, 32'h5);
        chk("nop_pc_uv", pc_uv, 32'h0);

        drive(2'd1, 3'd0, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0);
        chk("wrap_pc_uv", pc_uv, 32'h4);
        chk("wrap_rd_wc", {31'b0, rd_wc}, 32'd1);
        chk("wrap_rd_wv", rd_wv, 32'h0);
        cyc();
        ctrl_valid = 1'b0;
        chk("wrap_ign", {31'b0, ign}, 32'd1);
        #2 i_rst = 1'b0;
        #1;
        chk("rst_midflush_ign", {31'b0, ign}, 32'd0);
        cyc();
        i_rst = 1'b1;

`ifdef JUMP_STATS_EN
        for (int t = 0; t < 5; t++) begin
            drive(2'd1, 3'd0, 32'h100, 32'h20, 32'h0, 32'h0);
            ride_flush();
        end
        for (int t = 0; t < 3; t++) begin
            drive(2'd3, 3'd6, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1);
            cyc();
        end
        for (int t = 0; t < 2; t++) begin
            drive(2'd2, 3'd0, 32'h300, 32'h0, 32'h2002, 32'h0);
            cyc();
        end
        ctrl_valid = 1'b0;
        chk("stats_taken", tk_cnt, 32'd5);
        chk("stats_not_taken", ntk_cnt, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
